// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned DEF_XLEN     = 64;
  localparam int unsigned DEF_INST_LEN = 32;
  localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;

  // Fetch FSM: issue request, wait for response, or discard a squashed response.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_KILL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_out_buf.sv
// Output register backed by a 1-entry skid buffer, with valid/ready and flush.
module if_out_buf #(
  parameter int unsigned W = 96
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         skid_valid_o
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;

  // Next-state: flush wins; an empty or draining out reg refills from skid first, then input.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || ready_i) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = in_valid_i;
        if (in_valid_i) skid_data_d = in_data_i;
      end else if (in_valid_i) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_valid_i && !skid_valid_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign valid_o      = out_valid_q;
  assign data_o       = out_data_q;
  assign skid_valid_o = skid_valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem port, {pc, instr} to ID.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned      XLEN     = DEF_XLEN,
  parameter int unsigned      INST_LEN = DEF_INST_LEN,
  parameter logic [XLEN-1:0]  RESET_PC = DEF_RESET_PC[XLEN-1:0]
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  output logic                imem_req_valid_o,
  input  logic                imem_req_ready_i,
  output logic [XLEN-1:0]     imem_req_addr_o,
  input  logic                imem_resp_valid_i,
  input  logic [INST_LEN-1:0] imem_resp_data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [XLEN-1:0]     pc_o,
  output logic [INST_LEN-1:0] instr_o
);

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_e          state_q, state_d;
  logic [XLEN-1:0]       fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]       inflight_pc_q, inflight_pc_d;
  logic                  skid_valid;
  logic                  req_valid;
  logic                  accept;
  logic                  resp_fire;
  logic [XLEN+INST_LEN-1:0] buf_data;

  assign req_valid = (state_q == S_REQ) && !skid_valid && !redirect_i && !rst;
  assign accept    = req_valid && imem_req_ready_i;
  assign resp_fire = (state_q == S_WAIT) && imem_resp_valid_i && !redirect_i;

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = fetch_pc_q;

  // Next-state for fetch FSM and PCs; redirect overrides normal sequencing.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    case (state_q)
      S_REQ: begin
        if (accept) begin
          state_d       = S_WAIT;
          inflight_pc_d = fetch_pc_q;
          fetch_pc_d    = fetch_pc_q + PC_STEP;
        end
      end
      S_WAIT:  if (imem_resp_valid_i) state_d = S_REQ;
      S_KILL:  if (imem_resp_valid_i) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ALIGN_MASK;
      // Any request still in flight after this edge must have its response dropped.
      case (state_q)
        S_REQ:   state_d = accept ? S_KILL : S_REQ;
        S_WAIT:  state_d = imem_resp_valid_i ? S_REQ : S_KILL;
        S_KILL:  state_d = imem_resp_valid_i ? S_REQ : S_KILL;
        default: state_d = S_REQ;
      endcase
    end
  end

  // FSM and PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_REQ;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  if_out_buf #(
    .W (XLEN + INST_LEN)
  ) u_out_buf (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect_i),
    .in_valid_i   (resp_fire),
    .in_data_i    ({inflight_pc_q, imem_resp_data_i}),
    .ready_i      (ready_i),
    .valid_o      (valid_o),
    .data_o       (buf_data),
    .skid_valid_o (skid_valid)
  );

  assign pc_o    = buf_data[XLEN+INST_LEN-1:INST_LEN];
  assign instr_o = buf_data[INST_LEN-1:0];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural imem and scoreboard queues.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [63:0] imem_req_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        valid_o;
  logic        ready_i;
  logic [63:0] pc_o;
  logic [31:0] instr_o;

  int unsigned mem_lat = 1;
  int checks = 0;
  int errors = 0;

  logic [63:0] exp_pc_q[$];
  logic [63:0] exp_req_q[$];
  logic [63:0] obs_pc_q[$];
  logic [31:0] obs_instr_q[$];
  time         obs_t_q[$];
  logic [63:0] req_log_q[$];

  always #5 clk = ~clk;

  if_stage #(
    .XLEN     (64),
    .INST_LEN (32),
    .RESET_PC (64'h8000_0000)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .redirect_i        (redirect_i),
    .redirect_pc_i     (redirect_pc_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .valid_o           (valid_o),
    .ready_i           (ready_i),
    .pc_o              (pc_o),
    .instr_o           (instr_o)
  );

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0013;
  endfunction

  // Memory model: accept seen at negedge, response mem_lat cycles after the accepting edge.
  initial begin
    logic        acc;
    logic [63:0] acc_addr;
    logic [63:0] pend_addr;
    int unsigned cnt;
    cnt = 0;
    pend_addr = '0;
    imem_resp_valid_i = 1'b0;
    imem_resp_data_i  = '0;
    forever begin
      @(negedge clk);
      acc      = (imem_req_valid_o === 1'b1) && (imem_req_ready_i === 1'b1);
      acc_addr = imem_req_addr_o;
      if (acc) req_log_q.push_back(acc_addr);
      @(posedge clk);
      #1;
      imem_resp_valid_i = 1'b0;
      if (acc) begin
        cnt       = mem_lat;
        pend_addr = acc_addr;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_resp_valid_i = 1'b1;
          imem_resp_data_i  = instr_of(pend_addr);
        end
      end
    end
  end

  // ID-side monitor: records every completed transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (valid_o === 1'b1 && ready_i === 1'b1) begin
        obs_pc_q.push_back(pc_o);
        obs_instr_q.push_back(instr_o);
        obs_t_q.push_back($time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait until n requests have been accepted, then stop the memory accepting more.
  task automatic wait_reqs(input string tag, input int unsigned n);
    int unsigned k;
    k = 0;
    while (req_log_q.size() < n && k < 50) begin
      step(1);
      k++;
    end
    imem_req_ready_i = 1'b0;
    check({tag, "_req_budget"}, 64'(req_log_q.size() >= n), 64'd1);
  endtask

  // Pop and compare scoreboard queues against what was observed, then clear all.
  task automatic check_step(input string tag);
    check({tag, "_nxfer"}, 64'(obs_pc_q.size()), 64'(exp_pc_q.size()));
    for (int unsigned i = 0; i < exp_pc_q.size() && i < obs_pc_q.size(); i++) begin
      check({tag, "_pc"}, obs_pc_q[i], exp_pc_q[i]);
      check({tag, "_instr"}, 64'(obs_instr_q[i]), 64'(instr_of(exp_pc_q[i])));
    end
    check({tag, "_nreq"}, 64'(req_log_q.size()), 64'(exp_req_q.size()));
    for (int unsigned i = 0; i < exp_req_q.size() && i < req_log_q.size(); i++) begin
      check({tag, "_req_addr"}, req_log_q[i], exp_req_q[i]);
    end
    exp_pc_q.delete();
    exp_req_q.delete();
    obs_pc_q.delete();
    obs_instr_q.delete();
    obs_t_q.delete();
    req_log_q.delete();
  endtask

  initial begin
    rst              = 1'b1;
    redirect_i       = 1'b0;
    redirect_pc_i    = '0;
    imem_req_ready_i = 1'b0;
    ready_i          = 1'b1;
    mem_lat          = 1;

    // Reset state
    step(2);
    check("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_pc", pc_o, 64'd0);
    check("rst_instr", 64'(instr_o), 64'd0);

    // 1: sequential fetch, 1-cycle memory, ID always ready
    rst = 1'b0;
    imem_req_ready_i = 1'b1;
    step(1);
    check("t1_valid_e1", 64'(valid_o), 64'd0);
    step(1);
    check("t1_valid_e2", 64'(valid_o), 64'd1);
    check("t1_pc_e2", pc_o, 64'h8000_0000);
    step(8);
    imem_req_ready_i = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      exp_pc_q.push_back(64'h8000_0000 + 64'(4 * i));
      exp_req_q.push_back(64'h8000_0000 + 64'(4 * i));
    end
    step(4);
    check_step("t1");

    // 2: ID stalls 5 cycles; out holds A, skid takes B, requests stop
    ready_i = 1'b0;
    imem_req_ready_i = 1'b1;
    step(5);
    check("t2_hold_valid", 64'(valid_o), 64'd1);
    check("t2_hold_pc", pc_o, 64'h8000_0014);
    check("t2_hold_instr", 64'(instr_o), 64'(instr_of(64'h8000_0014)));
    check("t2_req_gated", 64'(imem_req_valid_o), 64'd0);
    ready_i = 1'b1;
    imem_req_ready_i = 1'b0;
    step(4);
    if (obs_t_q.size() >= 2) check("t2_back_to_back", 64'(obs_t_q[1] - obs_t_q[0]), 64'd10);
    else check("t2_back_to_back_count", 64'(obs_t_q.size()), 64'd2);
    exp_pc_q.push_back(64'h8000_0014);
    exp_pc_q.push_back(64'h8000_0018);
    exp_req_q.push_back(64'h8000_0014);
    exp_req_q.push_back(64'h8000_0018);
    check_step("t2");

    // 3: redirect to misaligned PC while waiting for a response
    mem_lat = 3;
    imem_req_ready_i = 1'b1;
    wait_reqs("t3a", 1);
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_1002;
    step(1);
    redirect_i = 1'b0;
    imem_req_ready_i = 1'b1;
    wait_reqs("t3b", 2);
    step(8);
    exp_req_q.push_back(64'h8000_001C);
    exp_req_q.push_back(64'h8000_1000);
    exp_pc_q.push_back(64'h8000_1000);
    check_step("t3");

    // 4: redirect on the same edge as the response
    mem_lat = 2;
    imem_req_ready_i = 1'b1;
    wait_reqs("t4a", 1);
    step(1);
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_2000;
    step(1);
    redirect_i = 1'b0;
    imem_req_ready_i = 1'b1;
    @(negedge clk);
    check("t4_req_next_valid", 64'(imem_req_valid_o), 64'd1);
    check("t4_req_next_addr", imem_req_addr_o, 64'h8000_2000);
    wait_reqs("t4b", 2);
    step(6);
    exp_req_q.push_back(64'h8000_1004);
    exp_req_q.push_back(64'h8000_2000);
    exp_pc_q.push_back(64'h8000_2000);
    check_step("t4");

    // 5: redirect while a request would be accepted
    mem_lat = 1;
    imem_req_ready_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 64'h8000_3003;
    @(negedge clk);
    check("t5_req_withdrawn", 64'(imem_req_valid_o), 64'd0);
    step(1);
    redirect_i = 1'b0;
    wait_reqs("t5", 1);
    step(4);
    exp_req_q.push_back(64'h8000_3000);
    exp_pc_q.push_back(64'h8000_3000);
    check_step("t5");

    // 6: asynchronous reset with out reg and skid full
    ready_i = 1'b0;
    imem_req_ready_i = 1'b1;
    step(6);
    check("t6_pre_valid", 64'(valid_o), 64'd1);
    check("t6_pre_req_gated", 64'(imem_req_valid_o), 64'd0);
    rst = 1'b1;
    #1;
    check("t6_async_valid", 64'(valid_o), 64'd0);
    check("t6_async_pc", pc_o, 64'd0);
    check("t6_async_req", 64'(imem_req_valid_o), 64'd0);
    step(2);
    exp_req_q.push_back(64'h8000_3004);
    exp_req_q.push_back(64'h8000_3008);
    check_step("t6a");
    rst = 1'b0;
    ready_i = 1'b1;
    wait_reqs("t6b", 1);
    step(4);
    exp_req_q.push_back(64'h8000_0000);
    exp_pc_q.push_back(64'h8000_0000);
    check_step("t6b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
